// File: rtl/wm8731_deserializer.sv
// rtl/wm8731_deserializer.sv - WM8731 ADCDAT receiver: left-justified stereo frames to parallel samples
// Optional averaged mono output when WM8731_ADC_MONO_MIX_EN is defined.
module wm8731_deserializer #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en32k,
  input  logic              bclk,
  input  logic              adc_dat,
  output logic              adc_lr_ck,
  output logic [DATA_W-1:0] audio_l,
  output logic [DATA_W-1:0] audio_r,
  output logic              audio_valid,
`ifdef WM8731_ADC_MONO_MIX_EN
  output logic [DATA_W-1:0] audio_mix,
`endif
  output logic              locked
);
  localparam int CNT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] LAST_L  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FIRST_R = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_R  = CNT_W'(2 * DATA_W - 1);

  typedef enum logic {ALIGN, RUN} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dat_s, bclk_q, rise, fall, do_align, sample_en;
  logic [CNT_W-1:0]       bit_cnt, cnt_nx;
  logic [DATA_W-2:0]      sh_l, sh_r;
  logic [DATA_W-1:0]      hold_l, word_l, word_r;

  assign dat_s  = sync_q[SYNC_STAGES-1];
  assign rise   = bclk & ~bclk_q;
  assign fall   = ~bclk & bclk_q;
  assign word_l = {sh_l, dat_s};
  assign word_r = {sh_r, dat_s};
  // Before the first alignment the counter is meaningless, so early rises are dropped.
  assign sample_en = rise && (state == RUN || locked);

`ifdef WM8731_ADC_MONO_MIX_EN
  logic signed [DATA_W:0]  mix_sum;
  logic        [DATA_W-1:0] mix_avg;
  assign mix_sum = $signed({hold_l[DATA_W-1], hold_l}) + $signed({word_r[DATA_W-1], word_r});
  assign mix_avg = DATA_W'(mix_sum >>> 1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ALIGN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_align = 1'b0;
    case (state)
      ALIGN: if (fall) begin
        state_nx = RUN;
        do_align = 1'b1;
      end
      RUN: if (en32k && fall) do_align = 1'b1;
           else if (en32k)    state_nx = ALIGN;
      default: state_nx = ALIGN;
    endcase
    cnt_nx = do_align ? '0 : bit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      bclk_q      <= 1'b0;
      bit_cnt     <= '0;
      adc_lr_ck   <= 1'b1;
      sh_l        <= '0;
      sh_r        <= '0;
      hold_l      <= '0;
      audio_l     <= '0;
      audio_r     <= '0;
      audio_valid <= 1'b0;
      locked      <= 1'b0;
`ifdef WM8731_ADC_MONO_MIX_EN
      audio_mix   <= '0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], adc_dat};
      bclk_q      <= bclk;
      audio_valid <= 1'b0;
      if (fall) begin
        bit_cnt   <= cnt_nx;
        adc_lr_ck <= ~cnt_nx[CNT_W-1];
        if (do_align) begin
          sh_l <= '0;
          sh_r <= '0;
          // A steady-state en32k lands on the 31->0 wrap and changes nothing.
          if (bit_cnt != LAST_R) locked <= 1'b0;
        end
      end else if (sample_en) begin
        if (bit_cnt < FIRST_R) begin
          sh_l <= word_l[DATA_W-2:0];
          if (bit_cnt == LAST_L) hold_l <= word_l;
        end else begin
          sh_r <= word_r[DATA_W-2:0];
          if (bit_cnt == LAST_R) begin
            audio_l     <= hold_l;
            audio_r     <= word_r;
            audio_valid <= 1'b1;
            locked      <= 1'b1;
`ifdef WM8731_ADC_MONO_MIX_EN
            audio_mix   <= mix_avg;
`endif
          end
        end
      end
    end
  end
endmodule
